// File: rtl/shift_cmd_queue_if.sv
// Command, shifter and result signals of shift_cmd_queue in one bundle.
//   slave  : the queue itself. It takes commands and the shifter result.
//            It drives the registered shifter operands, the result port and done_cnt.
//   master : the surrounding logic. It offers commands, supplies sh_dout and consumes results.
interface shift_cmd_queue_if #(
    parameter int DW = 8,
    parameter int SW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_din;
    logic [SW-1:0] cmd_shamt;
    logic          cmd_lr;
    logic          cmd_al;

    logic [DW-1:0] sh_din;
    logic [SW-1:0] sh_shamt;
    logic          sh_lr;
    logic          sh_al;
    logic [DW-1:0] sh_dout;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [7:0]    done_cnt;

    modport slave (
        input  cmd_valid, cmd_din, cmd_shamt, cmd_lr, cmd_al,
        input  sh_dout, res_ready,
        output cmd_ready,
        output sh_din, sh_shamt, sh_lr, sh_al,
        output res_valid, res_data, done_cnt
    );

    modport master (
        output cmd_valid, cmd_din, cmd_shamt, cmd_lr, cmd_al,
        output sh_dout, res_ready,
        input  cmd_ready,
        input  sh_din, sh_shamt, sh_lr, sh_al,
        input  res_valid, res_data, done_cnt
    );
endinterface

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: command stage in front of the combinational 8-bit barrel shifter.
// Shift commands are buffered in a DEPTH-entry FIFO and issued one at a time on
// registered operand lines. The shifter result is sampled one cycle after issue
// and presented on a valid/ready result port. A wrapping 8-bit count of
// completed result handshakes is also kept.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : shift_cmd_queue_if.slave
//            cmd_*    push side of the command FIFO (cmd_ready = not full)
//            sh_*     registered operands to the shifter, sh_dout its result
//            res_*    captured result, valid/ready handshake
//            done_cnt completed result handshakes, wraps 255 -> 0
//
// FSM states
//   state | meaning
//   IDLE  | nothing issued; pop the FIFO head into sh_* when it is non-empty
//   DRIVE | sh_* stable for one cycle; capture sh_dout at the edge
//   HOLD  | res_valid high until res_ready; then pop the next command or go idle
module shift_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int SW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_cmd_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] din;
        logic [SW-1:0] shamt;
        logic          lr;
        logic          al;
    } cmd_t;

    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state_q;
    state_t        state_d;

    logic          push;
    logic          pop;
    logic          capture;
    logic          res_drop;
    logic          done_inc;

    cmd_t          cmd_in;
    cmd_t          head;
    cmd_t          sh_q;
    logic          res_valid_q;
    logic [DW-1:0] res_data_q;
    logic [7:0]    done_q;

    // ---------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------
    assign bus.cmd_ready = (count != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;

    assign cmd_in.din   = bus.cmd_din;
    assign cmd_in.shamt = bus.cmd_shamt;
    assign cmd_in.lr    = bus.cmd_lr;
    assign cmd_in.al    = bus.cmd_al;

    // Reading the registered array gives the no-bypass behaviour.
    // A command written at an edge only appears at the head after that edge.
    assign head = fifo_mem[rd_ptr];

    // Storage needs no reset. count gates every read, so a stale entry is never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // pop is decided from the count before this cycle's push.
    // So a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Issue / capture FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        capture  = 1'b0;
        res_drop = 1'b0;
        done_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    done_inc = 1'b1;
                    res_drop = 1'b1;
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Registered shifter operands and result port
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (pop) begin
            sh_q <= head;
        end
    end

    // res_data holds its value after the handshake. Only res_valid drops.
    // During a back-to-back DRIVE the consumer sees valid low, not a stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.sh_dout;
        end else if (res_drop) begin
            res_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
        end else if (done_inc) begin
            done_q <= done_q + 1'b1;
        end
    end

    assign bus.sh_din    = sh_q.din;
    assign bus.sh_shamt  = sh_q.shamt;
    assign bus.sh_lr     = sh_q.lr;
    assign bus.sh_al     = sh_q.al;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.done_cnt  = done_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Testbench for shift_cmd_queue. It has directed scenarios followed by a randomized phase.
// Every cycle the outputs are compared against a transaction-level reference model.
module tb_shift_cmd_queue;
    localparam int DW    = 8;
    localparam int SW    = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] din;
        logic [2:0] shamt;
        logic       lr;
        logic       al;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_cmd_queue_if #(.DW(DW), .SW(SW)) bus ();

    shift_cmd_queue #(.DEPTH(DEPTH), .DW(DW), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] shift_ref(input logic [7:0] d, input logic [2:0] s,
                                             input logic lr, input logic al);
        logic [7:0] r;
        if (lr)      r = d << s;
        else if (al) r = 8'($signed(d) >>> s);
        else         r = d >> s;
        return r;
    endfunction

    // Behavioural barrel shifter standing in for the real one
    assign bus.sh_dout = shift_ref(bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al);

    // ---------------- reference model ----------------
    cmd_t       m_q[$];          // accepted, not yet issued
    cmd_t       m_cur;           // command on the shifter lines
    int         m_stage;         // 0 nothing issued, 1 issued this cycle, 2 result waiting
    logic       m_rv;
    logic [7:0] m_rd;
    logic [7:0] m_done;
    int         n_done_total;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur        = '0;
        m_stage      = 0;
        m_rv         = 1'b0;
        m_rd         = '0;
        m_done       = '0;
        n_done_total = 0;
    endtask

    task automatic check_outputs();
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() != DEPTH));
        chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
        chk("res_data",  32'(bus.res_data),  32'(m_rd));
        chk("sh_lines",  32'({bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al}), 32'(m_cur));
        chk("done_cnt",  32'(bus.done_cnt),  32'(m_done));
    endtask

    // One cycle: check the state left by the last edge, drive inputs, advance the model.
    task automatic step(input logic cv, input cmd_t c, input logic rr);
        bit    push;
        bit    nonempty;
        check_outputs();
        bus.cmd_valid = cv;
        {bus.cmd_din, bus.cmd_shamt, bus.cmd_lr, bus.cmd_al} = c;
        bus.res_ready = rr;
        push     = cv && (m_q.size() != DEPTH);
        nonempty = (m_q.size() != 0);
        case (m_stage)
            0: if (nonempty) begin
                m_cur   = m_q.pop_front();
                m_stage = 1;
            end
            1: begin
                m_rd    = shift_ref(m_cur.din, m_cur.shamt, m_cur.lr, m_cur.al);
                m_rv    = 1'b1;
                m_stage = 2;
            end
            default: if (rr) begin
                m_done++;
                n_done_total++;
                m_rv = 1'b0;
                if (nonempty) begin
                    m_cur   = m_q.pop_front();
                    m_stage = 1;
                end else begin
                    m_stage = 0;
                end
            end
        endcase
        if (push) m_q.push_back(c);
        @(negedge clk);
    endtask

    function automatic cmd_t rand_cmd();
        return cmd_t'(13'($urandom));
    endfunction

    task automatic apply_reset();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_din   = '0;
        bus.cmd_shamt = '0;
        bus.cmd_lr    = 1'b0;
        bus.cmd_al    = 1'b0;
        bus.res_ready = 1'b0;
        model_reset();

        @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_done",      32'(bus.done_cnt),  32'd0);
        chk("rst_sh",        32'({bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al}), 32'd0);
        apply_reset();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Arithmetic right: result visible two edges after acceptance
        step(1'b1, {8'h96, 3'd2, 1'b0, 1'b1}, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t1_no_early_valid", 32'(bus.res_valid), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_res_data",  32'(bus.res_data),  32'hE5);
        step(1'b0, '0, 1'b1);
        chk("t1_done", 32'(bus.done_cnt), 32'd1);

        // Left then logical right, back to back
        apply_reset();
        step(1'b1, {8'h96, 3'd1, 1'b1, 1'b0}, 1'b1);
        step(1'b1, {8'h96, 3'd3, 1'b0, 1'b0}, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t2_first",  32'(bus.res_data), 32'h2C);
        step(1'b0, '0, 1'b1);
        chk("t2_gap_valid", 32'(bus.res_valid), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("t2_second", 32'(bus.res_data), 32'h12);
        step(1'b0, '0, 1'b1);
        chk("t2_done", 32'(bus.done_cnt), 32'd2);

        // Fill under backpressure, then drain in order
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, rand_cmd(), 1'b0);
        chk("t3_full_ready", 32'(bus.cmd_ready), 32'd0);
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
        chk("t3_drained_done", 32'(bus.done_cnt), 32'd5);

        // Result held for ten cycles under backpressure
        apply_reset();
        step(1'b1, {8'h81, 3'd7, 1'b0, 1'b1}, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);
        chk("t4_held_valid", 32'(bus.res_valid), 32'd1);
        chk("t4_held_data",  32'(bus.res_data),  32'hFF);
        chk("t4_held_done",  32'(bus.done_cnt),  32'd0);
        step(1'b0, '0, 1'b1);

        // 256 completions wrap done_cnt and exercise pointer wrap
        apply_reset();
        guard = 0;
        while (n_done_total < 256 && guard < 2000) begin
            step(1'b1, rand_cmd(), 1'b1);
            guard++;
        end
        chk("t6_completions", 32'(n_done_total), 32'd256);
        chk("t6_wrap_done",   32'(bus.done_cnt), 32'd0);

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 60, rand_cmd(), $urandom_range(0, 99) < 70);

        // Reset while queued commands and a pending result exist
        for (int i = 0; i < 6; i++) step(1'b1, rand_cmd(), 1'b0);
        chk("t5_pending_valid", 32'(bus.res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(bus.res_valid), 32'd0);
        chk("t5_async_data",  32'(bus.res_data),  32'd0);
        chk("t5_async_done",  32'(bus.done_cnt),  32'd0);
        chk("t5_async_sh",    32'({bus.sh_din, bus.sh_shamt, bus.sh_lr, bus.sh_al}), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("t5_ready_after", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        chk("t5_no_stale", 32'(bus.res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
